// File: rtl/arilla_serial_tx.sv
// Serial transmitter that drains the arillaBus send FIFO.
// Each byte is sent as a start bit, DATA_W data bits LSB first, then STOP_BITS stop bits.
module arilla_serial_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       bit_time,
  input  logic              start_trans,
  input  logic              inv,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_ne,
  output logic              fifo_rd,
  output logic              tx,
  output logic              trans_ip,
  output logic              tx_done
);

  localparam int unsigned BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic              line_q, line_d;
  logic              fifo_rd_d, tx_done_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       bt_q, bt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shreg_shifted;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [1:0]        stopcnt_q, stopcnt_d;
  logic [31:0]       bt_eff;

  assign bt_eff        = (bit_time == 32'd0) ? 32'd1 : bit_time;
  assign shreg_shifted = shreg_q >> 1;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    bt_d      = bt_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    fifo_rd_d = 1'b0;
    tx_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_trans && fifo_ne) begin
          state_d   = S_LOAD;
          fifo_rd_d = 1'b1;
        end
      end

      S_LOAD: begin
        // The head word is still valid here; the pop takes effect at this same edge.
        shreg_d   = fifo_dout;
        bt_d      = bt_eff;
        cnt_d     = bt_eff - 32'd1;
        bitcnt_d  = '0;
        stopcnt_d = '0;
        line_d    = 1'b0;
        state_d   = S_START;
      end

      S_START: begin
        if (cnt_q == 32'd0) begin
          state_d = S_DATA;
          line_d  = shreg_q[0];
          cnt_d   = bt_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == 32'd0) begin
          cnt_d = bt_q - 32'd1;
          if (bitcnt_q == LAST_BIT) begin
            state_d = S_STOP;
            line_d  = 1'b1;
          end else begin
            shreg_d  = shreg_shifted;
            line_d   = shreg_shifted[0];
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == 32'd0) begin
          if (stopcnt_q == LAST_STOP) begin
            tx_done_d = 1'b1;
            if (fifo_ne) begin
              state_d   = S_LOAD;
              fifo_rd_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stopcnt_d = stopcnt_q + 1'b1;
            cnt_d     = bt_q - 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      line_q    <= 1'b1;
      fifo_rd   <= 1'b0;
      tx_done   <= 1'b0;
      cnt_q     <= '0;
      bt_q      <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      fifo_rd   <= fifo_rd_d;
      tx_done   <= tx_done_d;
      cnt_q     <= cnt_d;
      bt_q      <= bt_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
    end
  end

  assign trans_ip = (state_q != S_IDLE);
  assign tx       = line_q ^ inv;

endmodule

// File: tb/tb_arilla_serial_tx.sv
// Directed self-checking bench for arilla_serial_tx with a small FIFO model.
// Outputs are sampled on the falling clock edge; sample 0 of each run is the LOAD cycle.
module tb_arilla_serial_tx;

  logic        clk;
  logic        rst_n;
  logic [31:0] bit_time;
  logic        start_trans;
  logic        inv;
  logic [7:0]  fifo_dout;
  logic        fifo_ne;
  logic        fifo_rd;
  logic        tx;
  logic        trans_ip;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: the bench pushes, the DUT pops.
  logic [7:0] mem [0:7];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign fifo_ne   = (rd_ptr != wr_ptr);
  assign fifo_dout = mem[rd_ptr % 8];

  always @(posedge clk) if (fifo_rd && fifo_ne) rd_ptr <= rd_ptr + 1;

  logic txs   [0:199];
  logic rds   [0:199];
  logic tips  [0:199];
  logic dones [0:199];

  arilla_serial_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_time   (bit_time),
    .start_trans(start_trans),
    .inv        (inv),
    .fifo_dout  (fifo_dout),
    .fifo_ne    (fifo_ne),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .trans_ip   (trans_ip),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 8] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic pulse_start();
    @(negedge clk) start_trans = 1'b1;
    @(negedge clk) start_trans = 1'b0;
  endtask

  task automatic observe(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      txs[base+i]   = tx;
      rds[base+i]   = fifo_rd;
      tips[base+i]  = trans_ip;
      dones[base+i] = tx_done;
      @(negedge clk);
    end
  endtask

  function automatic int count_ones(input int sel, input int base, input int n);
    int c = 0;
    for (int i = base; i < base + n; i++) begin
      case (sel)
        0: c += (rds[i] === 1'b1) ? 1 : 0;
        1: c += (tips[i] === 1'b1) ? 1 : 0;
        2: c += (dones[i] === 1'b1) ? 1 : 0;
        default: c += (txs[i] === 1'b0) ? 1 : 0;
      endcase
    end
    return c;
  endfunction

  task automatic check_count(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Compares the LOAD cycle, the full 10-bit frame and the cycle after it.
  task automatic check_frame(input string nm, input int base, input logic [7:0] d,
                             input int bt, input logic iv);
    logic e;
    int   k;
    for (int c = 0; c <= 10 * bt + 1; c++) begin
      if (c == 0 || c > 10 * bt) e = 1'b1;
      else begin
        k = (c - 1) / bt;
        if (k == 0)      e = 1'b0;
        else if (k == 9) e = 1'b1;
        else             e = d[k-1];
      end
      e = e ^ iv;
      n_checks++;
      if (txs[base+c] !== e) begin
        n_fail++;
        $display("FAIL %s tx cycle %0d: got %b, expected %b", nm, c, txs[base+c], e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_trans = 1'b0; inv = 1'b0; bit_time = 32'd4;
    #12;
    n_checks++;
    if (tx !== 1'b1 || trans_ip !== 1'b0 || fifo_rd !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got tx=%b ip=%b rd=%b done=%b, expected 1 0 0 0",
               tx, trans_ip, fifo_rd, tx_done);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    flush(); bit_time = 32'd4; push(8'hA5);
    pulse_start();
    n_checks++;
    if (rds[0] !== rds[0] || fifo_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL single load rd: got %b, expected 1", fifo_rd);
    end
    observe(0, 60);
    check_frame("single", 0, 8'hA5, 4, 1'b0);
    check_count("single rd pulses", count_ones(0, 0, 60), 1);
    check_count("single tx_done pulses", count_ones(2, 0, 60), 1);
    check_count("single trans_ip cycles", count_ones(1, 0, 60), 41);
  endtask

  task automatic test_back_to_back();
    int second_rd = -1;
    flush(); bit_time = 32'd2; push(8'h00); push(8'hFF);
    pulse_start();
    observe(0, 60);
    for (int i = 1; i < 60; i++) if (rds[i] === 1'b1 && second_rd < 0) second_rd = i;
    check_count("b2b rd pulses", count_ones(0, 0, 60), 2);
    check_count("b2b rd spacing", second_rd, 21);
    check_count("b2b trans_ip continuous", count_ones(1, 0, 42), 42);
    check_count("b2b trans_ip total", count_ones(1, 0, 60), 42);
    check_count("b2b tx_done pulses", count_ones(2, 0, 60), 2);
    check_frame("b2b frame0", 0, 8'h00, 2, 1'b0);
    check_frame("b2b frame1", 21, 8'hFF, 2, 1'b0);
  endtask

  task automatic test_empty_fifo();
    flush(); bit_time = 32'd4;
    pulse_start();
    observe(0, 50);
    check_count("empty rd pulses", count_ones(0, 0, 50), 0);
    check_count("empty trans_ip cycles", count_ones(1, 0, 50), 0);
    check_count("empty tx low cycles", count_ones(3, 0, 50), 0);
  endtask

  task automatic test_bit_time_zero();
    flush(); bit_time = 32'd0; push(8'h01);
    pulse_start();
    observe(0, 20);
    check_frame("bt0", 0, 8'h01, 1, 1'b0);
    check_count("bt0 trans_ip cycles", count_ones(1, 0, 20), 11);
  endtask

  task automatic test_invert();
    flush(); bit_time = 32'd4; inv = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL inv idle level: got %b, expected 0", tx);
    end
    push(8'hA5);
    pulse_start();
    observe(0, 50);
    check_frame("inv", 0, 8'hA5, 4, 1'b1);
    inv = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL inv release: got %b, expected 1", tx);
    end
  endtask

  task automatic test_reset_mid_frame();
    flush(); bit_time = 32'd4; push(8'hA5);
    pulse_start();
    observe(0, 18);             // now at frame cycle 18: data bit 3
    n_checks++;
    if (trans_ip !== 1'b1 || tx !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe pre-reset: got ip=%b tx=%b, expected 1 0", trans_ip, tx);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1 || trans_ip !== 1'b0 || fifo_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe reset: got tx=%b ip=%b rd=%b, expected 1 0 0", tx, trans_ip, fifo_rd);
    end
    @(negedge clk) rst_n = 1'b1;
    flush(); bit_time = 32'd3; push(8'h5A);
    pulse_start();
    observe(0, 40);
    check_frame("post-reset", 0, 8'h5A, 3, 1'b0);
    check_count("post-reset trans_ip cycles", count_ones(1, 0, 40), 31);
    check_count("post-reset rd pulses", count_ones(0, 0, 40), 1);
  endtask

  task automatic test_bit_time_change();
    flush(); bit_time = 32'd4; push(8'h3C); push(8'hC3);
    pulse_start();
    observe(0, 10);
    bit_time = 32'd8;
    observe(10, 125);
    check_frame("btchg frame0", 0, 8'h3C, 4, 1'b0);
    check_frame("btchg frame1", 41, 8'hC3, 8, 1'b0);
    check_count("btchg trans_ip cycles", count_ones(1, 0, 135), 122);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_empty_fifo();
    test_bit_time_zero();
    test_invert();
    test_reset_mid_frame();
    test_bit_time_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
